mem_arr_feeder: RTL and testbench

// - Read-side controller for the per-lane input memory array: drives per-lane rd_en/rd_addr, captures q.
// - Issues diagonally skewed reads so lane i trails lane 0 by i cycles, as the systolic array needs.
// - Sits between the memory array's read ports and the systolic array's row/column inputs.
// - Start/busy/done handshake toward the TPU top-level sequencer.

---
 rtl/mem_arr_feeder_pkg.sv | 7 +
 rtl/mem_arr_feeder_if.sv | 37 +++
 rtl/mem_arr_feeder_lane.sv | 35 +++
 rtl/mem_arr_feeder.sv | 94 +++++++++
 tb/tb_mem_arr_feeder.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/mem_arr_feeder_pkg.sv
// tpu_feeder_pkg: FSM state encoding and default lane/width constants for mem_arr_feeder.
package tpu_feeder_pkg;
    localparam int DEF_WIDTH_HEIGHT = 4;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
endpackage

// File: rtl/mem_arr_feeder_if.sv
// mem_arr_feeder_if: sequencer handshake, memory read ports and array feed bus of mem_arr_feeder.
// The stall input exists only when FEEDER_STALL_EN is defined.
interface mem_arr_feeder_if
    import tpu_feeder_pkg::*;
#(
    parameter int WIDTH_HEIGHT = DEF_WIDTH_HEIGHT,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] num_rows;
    logic busy;
    logic done;
    logic [WIDTH_HEIGHT-1:0] rd_en;
    logic [WIDTH_HEIGHT*ADDR_W-1:0] rd_addr;
    logic [WIDTH_HEIGHT*DATA_W-1:0] rd_data;
    logic [WIDTH_HEIGHT*DATA_W-1:0] out_data;
    logic [WIDTH_HEIGHT-1:0] out_valid;
`ifdef FEEDER_STALL_EN
    logic stall;
`endif
    modport master (
`ifdef FEEDER_STALL_EN
        input stall,
`endif
        input start, base_addr, num_rows, rd_data,
        output busy, done, rd_en, rd_addr, out_data, out_valid
    );
    modport slave (
`ifdef FEEDER_STALL_EN
        output stall,
`endif
        output start, base_addr, num_rows, rd_data,
        input busy, done, rd_en, rd_addr, out_data, out_valid
    );
endinterface

// File: rtl/mem_arr_feeder_lane.sv
// mem_arr_feeder_lane: one lane's registered read enable/address and the 1-cycle valid delay.
module mem_arr_feeder_lane
    import tpu_feeder_pkg::*;
#(
    parameter int IDX = 0,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_issue,
    input  logic [ADDR_W:0]   i_t,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_rows,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_valid
);
    localparam int TW = ADDR_W + 1;
    logic [TW:0] w_off;
    logic w_en;
    // One extra bit so t < IDX shows up as a borrow instead of wrapping.
    assign w_off = {1'b0, i_t} - (TW+1)'(IDX);
    assign w_en = i_issue && !w_off[TW] && (w_off[TW-1:0] < {1'b0, i_rows});
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rd_en <= 1'b0;
            o_rd_addr <= '0;
            o_valid <= 1'b0;
        end else begin
            o_rd_en <= w_en;
            if (w_en) o_rd_addr <= i_base + w_off[ADDR_W-1:0];
            o_valid <= o_rd_en;
        end
    end
endmodule

// File: rtl/mem_arr_feeder.sv
// mem_arr_feeder: skewed per-lane reads from the input memory array into the systolic array.
// Define FEEDER_STALL_EN to add a stall input that freezes issue while in ISSUE.
module mem_arr_feeder
    import tpu_feeder_pkg::*;
#(
    parameter int WIDTH_HEIGHT = DEF_WIDTH_HEIGHT,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input logic clk,
    input logic rst_n,
    mem_arr_feeder_if.master bus
);
    localparam int TW = ADDR_W + 1;
    state_t r_state;
    logic [TW-1:0] r_t;
    logic [ADDR_W-1:0] r_base, r_rows;
    logic r_busy, r_done;
    logic w_stall, w_accept, w_adv, w_end, w_issue;
    logic [TW-1:0] w_last, w_t_nxt;
    logic [ADDR_W-1:0] w_base, w_rows;
    logic [WIDTH_HEIGHT-1:0] w_rd_en, w_valid;
    logic [WIDTH_HEIGHT-1:0][ADDR_W-1:0] w_rd_addr;
`ifdef FEEDER_STALL_EN
    assign w_stall = bus.stall;
`else
    assign w_stall = 1'b0;
`endif
    assign w_last = {1'b0, r_rows} + TW'(WIDTH_HEIGHT - 2);
    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_adv = (r_state == ISSUE) && !w_stall;
    assign w_end = w_adv && (r_t == w_last);
    // Lanes register from next-cycle t so rd_en lines up with the cycle whose t it belongs to.
    assign w_issue = (w_accept && bus.num_rows != '0) || (w_adv && !w_end);
    assign w_t_nxt = w_accept ? '0 : r_t + TW'(1);
    assign w_base = w_accept ? bus.base_addr : r_base;
    assign w_rows = w_accept ? bus.num_rows : r_rows;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_t <= '0;
            r_base <= '0;
            r_rows <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_base <= bus.base_addr;
                        r_rows <= bus.num_rows;
                        r_t <= '0;
                        r_state <= (bus.num_rows != '0) ? ISSUE : DRAIN;
                        r_busy <= bus.num_rows != '0;
                        r_done <= bus.num_rows == '0;
                    end
                end
                ISSUE: begin
                    if (w_adv) r_t <= r_t + TW'(1);
                    if (w_end) begin
                        r_state <= DRAIN;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                DRAIN: begin
                    r_done <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    for (genvar g = 0; g < WIDTH_HEIGHT; g++) begin : g_lane
        mem_arr_feeder_lane #(.IDX(g), .ADDR_W(ADDR_W)) u_lane (
            .clk(clk),
            .rst_n(rst_n),
            .i_issue(w_issue),
            .i_t(w_t_nxt),
            .i_base(w_base),
            .i_rows(w_rows),
            .o_rd_en(w_rd_en[g]),
            .o_rd_addr(w_rd_addr[g]),
            .o_valid(w_valid[g])
        );
        assign bus.out_data[g*DATA_W +: DATA_W] = w_valid[g] ? bus.rd_data[g*DATA_W +: DATA_W] : '0;
    end
    assign bus.rd_en = w_rd_en;
    assign bus.rd_addr = w_rd_addr;
    assign bus.out_valid = w_valid;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_mem_arr_feeder.sv
// tb_mem_arr_feeder: directed checks of skewed issue, wrap, zero rows, restart and async reset.
module tb_mem_arr_feeder;
    localparam int W = 4, AW = 8, DW = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    logic [W*DW-1:0] rdata = 32'hD3C2B1A0;

    mem_arr_feeder_if #(.WIDTH_HEIGHT(W), .ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_arr_feeder #(.WIDTH_HEIGHT(W), .ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] lane_addr(input int i);
        return bus.rd_addr[i*AW +: AW];
    endfunction

    function automatic logic [W*DW-1:0] masked(input logic [W-1:0] v);
        logic [W*DW-1:0] r;
        for (int i = 0; i < W; i++) r[i*DW +: DW] = v[i] ? rdata[i*DW +: DW] : '0;
        return r;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic start_pass(input logic [AW-1:0] b, input logic [AW-1:0] r);
        bus.start = 1'b1;
        bus.base_addr = b;
        bus.num_rows = r;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        cyc();
        cyc();
        n_chk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got %b%b exp 00", bus.busy, bus.done); end
        n_chk++; if (bus.rd_en !== '0) begin n_fail++; $display("FAIL reset_rd_en got %b exp 0", bus.rd_en); end
        n_chk++; if (bus.rd_addr !== '0) begin n_fail++; $display("FAIL reset_rd_addr got %h exp 0", bus.rd_addr); end
        n_chk++; if (bus.out_valid !== '0 || bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out got %b/%h exp 0/0", bus.out_valid, bus.out_data); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        logic [W-1:0] e_en [8];
        logic [W-1:0] e_val [8];
        e_en = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000};
        e_val = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        start_pass(8'h10, 8'd3);
        for (int k = 0; k < 8; k++) begin
            n_chk++; if (bus.rd_en !== e_en[k]) begin n_fail++; $display("FAIL basic_en k=%0d got %b exp %b", k, bus.rd_en, e_en[k]); end
            n_chk++; if (bus.out_valid !== e_val[k]) begin n_fail++; $display("FAIL basic_valid k=%0d got %b exp %b", k, bus.out_valid, e_val[k]); end
            n_chk++; if (bus.out_data !== masked(e_val[k])) begin n_fail++; $display("FAIL basic_data k=%0d got %h exp %h", k, bus.out_data, masked(e_val[k])); end
            n_chk++; if (bus.busy !== (k <= 5)) begin n_fail++; $display("FAIL basic_busy k=%0d got %b exp %b", k, bus.busy, k <= 5); end
            n_chk++; if (bus.done !== (k == 6)) begin n_fail++; $display("FAIL basic_done k=%0d got %b exp %b", k, bus.done, k == 6); end
            for (int i = 0; i < W; i++)
                if (e_en[k][i]) begin
                    n_chk++; if (lane_addr(i) !== 8'h10 + 8'(k - i)) begin n_fail++; $display("FAIL basic_addr k=%0d lane=%0d got %h exp %h", k, i, lane_addr(i), 8'h10 + 8'(k - i)); end
                end
            cyc();
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] e_a [4];
        e_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        start_pass(8'hFE, 8'd4);
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                n_chk++; if (bus.rd_en[0] !== 1'b1 || lane_addr(0) !== e_a[k]) begin n_fail++; $display("FAIL wrap_lane0 k=%0d got %b/%h exp 1/%h", k, bus.rd_en[0], lane_addr(0), e_a[k]); end
            end
            if (k >= 3 && k < 7) begin
                n_chk++; if (bus.rd_en[3] !== 1'b1 || lane_addr(3) !== e_a[k-3]) begin n_fail++; $display("FAIL wrap_lane3 k=%0d got %b/%h exp 1/%h", k, bus.rd_en[3], lane_addr(3), e_a[k-3]); end
            end
            n_chk++; if (bus.done !== (k == 7)) begin n_fail++; $display("FAIL wrap_done k=%0d got %b exp %b", k, bus.done, k == 7); end
            cyc();
        end
    endtask

    task automatic test_zero_rows();
        start_pass(8'h55, 8'd0);
        n_chk++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_done_busy got %b%b exp 10", bus.done, bus.busy); end
        n_chk++; if (bus.rd_en !== '0) begin n_fail++; $display("FAIL zero_rd_en got %b exp 0", bus.rd_en); end
        cyc();
        n_chk++; if (bus.done !== 1'b0 || bus.out_valid !== '0) begin n_fail++; $display("FAIL zero_after got %b/%b exp 0/0", bus.done, bus.out_valid); end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e_en [6];
        e_en = '{4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1000, 4'b0000};
        start_pass(8'h20, 8'd2);
        for (int k = 0; k < 6; k++) begin
            n_chk++; if (bus.rd_en !== e_en[k]) begin n_fail++; $display("FAIL b2b_en k=%0d got %b exp %b", k, bus.rd_en, e_en[k]); end
            n_chk++; if (bus.done !== (k == 5)) begin n_fail++; $display("FAIL b2b_done k=%0d got %b exp %b", k, bus.done, k == 5); end
            if (k == 2) begin
                n_chk++; if (lane_addr(0) !== 8'h21 || lane_addr(1) !== 8'h21) begin n_fail++; $display("FAIL b2b_addr got %h/%h exp 21/21", lane_addr(0), lane_addr(1)); end
            end
            bus.start = (k == 1);
            bus.base_addr = 8'h80;
            bus.num_rows = 8'd5;
            cyc();
        end
        n_chk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b%b exp 00", bus.busy, bus.done); end
        start_pass(8'h40, 8'd1);
        for (int k = 0; k < 5; k++) begin
            n_chk++; if (bus.rd_en !== ((k < 4) ? 4'(1 << k) : 4'b0000)) begin n_fail++; $display("FAIL restart_en k=%0d got %b", k, bus.rd_en); end
            if (k < 4) begin
                n_chk++; if (lane_addr(k) !== 8'h40) begin n_fail++; $display("FAIL restart_addr k=%0d got %h exp 40", k, lane_addr(k)); end
            end
            n_chk++; if (bus.done !== (k == 4)) begin n_fail++; $display("FAIL restart_done k=%0d got %b exp %b", k, bus.done, k == 4); end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        start_pass(8'h10, 8'd3);
        cyc();
        cyc();
        n_chk++; if (bus.rd_en !== 4'b0111) begin n_fail++; $display("FAIL midrst_pre got %b exp 0111", bus.rd_en); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (bus.rd_en !== '0 || bus.out_valid !== '0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_drop got %b/%b/%b exp 0/0/0", bus.rd_en, bus.out_valid, bus.busy); end
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_chk++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.rd_en !== '0) begin n_fail++; $display("FAIL midrst_quiet k=%0d got %b%b/%b exp 00/0", k, bus.done, bus.busy, bus.rd_en); end
            cyc();
        end
    endtask

`ifdef FEEDER_STALL_EN
    task automatic test_stall();
        logic [W-1:0] e_en [7];
        e_en = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        start_pass(8'h10, 8'd3);
        bus.stall = 1'b1;
        cyc();
        n_chk++; if (bus.rd_en !== '0 || bus.out_valid !== 4'b0001) begin n_fail++; $display("FAIL stall_1 got %b/%b exp 0000/0001", bus.rd_en, bus.out_valid); end
        cyc();
        n_chk++; if (bus.rd_en !== '0 || bus.out_valid !== '0) begin n_fail++; $display("FAIL stall_2 got %b/%b exp 0/0", bus.rd_en, bus.out_valid); end
        bus.stall = 1'b0;
        cyc();
        n_chk++; if (lane_addr(0) !== 8'h11) begin n_fail++; $display("FAIL stall_resume_addr got %h exp 11", lane_addr(0)); end
        for (int k = 1; k < 7; k++) begin
            n_chk++; if (bus.rd_en !== e_en[k]) begin n_fail++; $display("FAIL stall_en k=%0d got %b exp %b", k, bus.rd_en, e_en[k]); end
            n_chk++; if (bus.done !== (k == 6)) begin n_fail++; $display("FAIL stall_done k=%0d got %b exp %b", k, bus.done, k == 6); end
            cyc();
        end
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.num_rows = '0;
        bus.rd_data = rdata;
`ifdef FEEDER_STALL_EN
        bus.stall = 1'b0;
`endif
        test_reset();
        test_basic();
        test_wrap();
        test_zero_rows();
        test_back_to_back();
        test_reset_mid();
`ifdef FEEDER_STALL_EN
        test_stall();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
